// File: rtl/ctr_sched_2req_pkg.sv
// Shared definitions for the two-requester counter scheduler: FSM encoding and defaults.
package ctr_sched_2req_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH      = 9;
  localparam int DEF_CLR_CYCLES = 1;
  localparam int CLR_CNT_W      = 8;

endpackage

// File: rtl/ctr_sched_2req_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that was not served last wins.
module rr_arb2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  output logic [1:0] gnt
);

  // last holds the index of the previous winner
  always_comb begin
    gnt = 2'b00;
    if (req0 && req1) begin
      gnt = last ? 2'b01 : 2'b10;
    end else if (req0) begin
      gnt = 2'b01;
    end else if (req1) begin
      gnt = 2'b10;
    end else begin
      gnt = 2'b00;
    end
  end

endmodule

// File: rtl/ctr_sched_2req.sv
// Shares one counter between two requesters: grant, clear, count to the latched target,
// pulse done, release.
module ctr_sched_2req
  import ctr_sched_2req_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int CLR_CYCLES = DEF_CLR_CYCLES
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] tgt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] tgt1,
  input  logic             pause,
  input  logic [WIDTH-1:0] count,
  output logic             ctr_enable,
  output logic             ctr_clr,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy
);

  localparam logic [CLR_CNT_W-1:0] CLR_LOAD = CLR_CNT_W'(CLR_CYCLES - 1);

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     tgt_q, tgt_nxt;
  logic                 last, last_nxt;
  logic [CLR_CNT_W-1:0] clr_cnt, clr_cnt_nxt;
  logic [1:0]           gnt_nxt, done_nxt, arb_gnt;
  logic                 granted_req, at_tgt;

  rr_arb2 u_arb (
    .req0 (req0),
    .req1 (req1),
    .last (last),
    .gnt  (arb_gnt)
  );

  assign granted_req = (gnt0 & req0) | (gnt1 & req1);
  assign at_tgt      = (count == tgt_q);

  // Enable is decoded from state so the counter halts on the very edge it reaches the target
  assign ctr_clr    = (state == S_CLEAR);
  assign ctr_enable = (state == S_RUN) && !pause && !at_tgt;
  assign busy       = (state != S_IDLE);

  // Next-state, grant, done and target capture
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = {gnt1, gnt0};
    done_nxt    = 2'b00;
    tgt_nxt     = tgt_q;
    last_nxt    = last;
    clr_cnt_nxt = clr_cnt;
    case (state)
      S_IDLE: begin
        if (arb_gnt != 2'b00) begin
          state_nxt   = S_CLEAR;
          gnt_nxt     = arb_gnt;
          tgt_nxt     = arb_gnt[1] ? tgt1 : tgt0;
          last_nxt    = arb_gnt[1];
          clr_cnt_nxt = CLR_LOAD;
        end else begin
          gnt_nxt = 2'b00;
        end
      end
      S_CLEAR: begin
        if (!granted_req) begin
          state_nxt = S_IDLE;
          gnt_nxt   = 2'b00;
        end else if (clr_cnt == {CLR_CNT_W{1'b0}}) begin
          state_nxt = S_RUN;
        end else begin
          clr_cnt_nxt = clr_cnt - {{(CLR_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_RUN: begin
        // A dropped request wins over reaching the target: no done for an abandoned job
        if (!granted_req) begin
          state_nxt = S_IDLE;
          gnt_nxt   = 2'b00;
        end else if (at_tgt) begin
          state_nxt = S_DONE;
          done_nxt  = {gnt1, gnt0};
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        gnt_nxt   = 2'b00;
      end
      default: begin
        state_nxt = S_IDLE;
        gnt_nxt   = 2'b00;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= S_IDLE;
      tgt_q   <= {WIDTH{1'b0}};
      last    <= 1'b1;
      clr_cnt <= {CLR_CNT_W{1'b0}};
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
    end else begin
      state   <= state_nxt;
      tgt_q   <= tgt_nxt;
      last    <= last_nxt;
      clr_cnt <= clr_cnt_nxt;
      gnt0    <= gnt_nxt[0];
      gnt1    <= gnt_nxt[1];
      done0   <= done_nxt[0];
      done1   <= done_nxt[1];
    end
  end

endmodule

// File: tb/tb_ctr_sched_2req.sv
// Self-checking bench for ctr_sched_2req: directed scenarios plus randomized jobs
// checked against a transaction-level latency/arbitration model.
module tb_ctr_sched_2req;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         clr_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0, pause = 1'b0;
  logic [W-1:0] tgt0 = '0, tgt1 = '0, count = '0;
  logic         ctr_enable, ctr_clr, gnt0, gnt1, done0, done1, busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit last_m  = 1'b1;

  ctr_sched_2req #(.WIDTH(W), .CLR_CYCLES(1)) dut (
    .clk(clk), .clr_n(clr_n), .req0(req0), .tgt0(tgt0), .req1(req1), .tgt1(tgt1),
    .pause(pause), .count(count), .ctr_enable(ctr_enable), .ctr_clr(ctr_clr),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .busy(busy)
  );

  always #50 clk = ~clk;

  // Shared counter: synchronous clear has priority over enable
  always_ff @(posedge clk) begin
    if (ctr_clr) count <= '0;
    else if (ctr_enable) count <= count + 9'd1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One job: done expected CLR_CYCLES + T + 1 + paused cycles after the grant edge
  task automatic run_txn(input bit r0, input bit r1, input int t0, input int t1,
                         input int ps, input int pl, input int abort_at, input bit keep_loser);
    int win, t, d, pl_e, ab_e;
    req0 = r0; req1 = r1; tgt0 = W'(t0); tgt1 = W'(t1); pause = 1'b0;
    win = (r0 && r1) ? (last_m ? 0 : 1) : (r1 ? 1 : 0);
    last_m = (win == 1);
    t = win ? t1 : t0;
    ab_e = (abort_at >= 0 && abort_at <= t) ? abort_at : -1;
    pl_e = (ab_e < 0 && t > 0 && ps >= 1 && ps <= t) ? pl : 0;
    d = 1 + t + 1 + pl_e;
    tick();
    check("grant", {gnt1, gnt0}, win ? 2'b10 : 2'b01);
    check("busy_grant", busy, 1);
    check("clr_pulse", {ctr_clr, ctr_enable}, 2'b10);
    if (win == 1) begin
      tgt1 = ~tgt1;
      if (!keep_loser) req0 = 1'b0;
    end else begin
      tgt0 = ~tgt0;
      if (!keep_loser) req1 = 1'b0;
    end
    for (int k = 1; k <= d + 1; k++) begin
      pause = (ab_e < 0) && ((k - 1) >= ps) && ((k - 1) < ps + pl_e);
      if (k - 1 == ab_e) begin
        if (win == 1) req1 = 1'b0; else req0 = 1'b0;
      end
      tick();
      if (ab_e >= 0 && k == ab_e + 1) begin
        check("abort_state", {busy, gnt1, gnt0, done1, done0}, 5'b0);
        break;
      end
      if (k == 1) check("cleared", count, 0);
      if (k < d) begin
        check("no_early_done", {done1, done0}, 2'b00);
      end else if (k == d) begin
        check("done", {done1, done0}, win ? 2'b10 : 2'b01);
        check("done_count", count, t);
        check("done_en", ctr_enable, 0);
        check("done_gnt", {gnt1, gnt0}, win ? 2'b10 : 2'b01);
        if (win == 1) req1 = 1'b0; else req0 = 1'b0;
      end else begin
        check("release", {busy, gnt1, gnt0, done1, done0}, 5'b0);
      end
    end
    pause = 1'b0;
  endtask

  initial begin
    bit p0, p1, r0, r1, kl;
    int ab;
    p0 = 1'b0; p1 = 1'b0;

    #120;
    check("reset_outs", {gnt0, gnt1, done0, done1, busy, ctr_enable, ctr_clr}, 7'b0);
    check("reset_busy", busy, 0);
    #30;
    @(negedge clk);
    clr_n = 1'b1;
    tick();

    run_txn(1'b1, 1'b0, 5, 0, 0, 0, -1, 1'b0);
    run_txn(1'b1, 1'b1, 3, 4, 0, 0, -1, 1'b1);
    run_txn(1'b0, 1'b1, 0, 4, 0, 0, -1, 1'b0);
    run_txn(1'b1, 1'b1, 3, 4, 0, 0, -1, 1'b0);
    run_txn(1'b0, 1'b1, 0, 10, 5, 3, -1, 1'b0);
    run_txn(1'b1, 1'b0, 0, 0, 0, 0, -1, 1'b0);
    run_txn(1'b0, 1'b1, 0, 20, 0, 0, 9, 1'b0);
    run_txn(1'b1, 1'b0, 511, 0, 0, 0, -1, 1'b0);

    repeat (40) begin
      r0 = p0 | 1'($urandom_range(0, 1));
      r1 = p1 | 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      kl = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 20)) : -1;
      run_txn(r0, r1, int'($urandom_range(0, 25)), int'($urandom_range(0, 25)),
              int'($urandom_range(1, 20)), int'($urandom_range(0, 3)), ab, kl);
      p0 = 1'b0; p1 = 1'b0;
      if (kl && r0 && r1) begin
        if (last_m) p0 = 1'b1; else p1 = 1'b1;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();

    req0 = 1'b1; tgt0 = 9'd20;
    tick();
    for (int i = 0; i < 40 && count != 9'd6; i++) tick();
    check("reach_6", count, 6);
    #20;
    clr_n = 1'b0;
    #1;
    check("rst_async", {ctr_enable, busy, gnt1, gnt0, done1, done0, ctr_clr}, 7'b0);
    req0 = 1'b0;
    last_m = 1'b1;
    @(negedge clk);
    clr_n = 1'b1;
    tick();
    run_txn(1'b1, 1'b0, 2, 0, 0, 0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
